// File: rtl/bram_rmw_ctrl.sv
// bram_rmw_ctrl
//   Read-modify-write accumulation controller in front of a simple dual-port
//   BRAM (one registered read port, one write port). Each accepted update
//   performs ram[addr] <= ram[addr] + inc at one update per cycle. Same-address
//   hazards are resolved by forwarding from the write stage (S2) and from a
//   one-cycle copy of the last write (S3). The block also zero-fills the BRAM
//   after reset or on request and serves host reads through the shared read
//   port (updates have strict priority).
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   upd_valid/upd_ready/upd_addr/upd_data   update stream (addr, increment)
//   rd_valid_in/rd_ready/rd_addr    host read request
//   rd_valid/rd_data                host read response, one cycle after accept
//   clr_start/clr_done              full-memory clear request / end pulse
//   busy                            high whenever not in RUN
//   bram_r_addr/bram_dout           BRAM read port (1-cycle registered read)
//   bram_w_addr/bram_we/bram_din    BRAM write port
module bram_rmw_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_data,
    input  logic              rd_valid_in,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr_start,
    output logic              clr_done,
    output logic              busy,
    output logic [ADDR_W-1:0] bram_r_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [ADDR_W-1:0] bram_w_addr,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_din
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;

    // S1: op whose BRAM read is returning this cycle
    logic              s1_valid, s1_rd;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_inc;
    // S2: write stage
    logic              s2_valid;
    logic [ADDR_W-1:0] s2_addr;
    logic [DATA_W-1:0] s2_sum;
    // S3: last write, kept one cycle because a read that sampled the BRAM on
    // the same edge as that write still returned the old contents
    logic              s3_valid;
    logic [ADDR_W-1:0] s3_addr;
    logic [DATA_W-1:0] s3_sum;

    logic              upd_acc, rd_acc;
    logic [DATA_W-1:0] fwd_val, s1_sum;

    // Youngest matching write wins
    always_comb begin
        if (s2_valid && s2_addr == s1_addr)
            fwd_val = s2_sum;
        else if (s3_valid && s3_addr == s1_addr)
            fwd_val = s3_sum;
        else
            fwd_val = bram_dout;
    end

    assign s1_sum = fwd_val + s1_inc;

    always_comb begin
        state_nxt   = state;
        upd_ready   = 1'b0;
        rd_ready    = 1'b0;
        clr_done    = 1'b0;
        bram_we     = 1'b0;
        bram_w_addr = '0;
        bram_din    = '0;
        busy        = (state != RUN);
        rd_valid    = s1_valid && s1_rd;
        rd_data     = (s1_valid && s1_rd) ? fwd_val : '0;

        case (state)
            CLEAR: begin
                bram_we     = 1'b1;
                bram_w_addr = cnt;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = RUN;
                    clr_done  = 1'b1;
                end
            end
            RUN: begin
                // The cycle clr_start is seen accepts nothing
                upd_ready = !clr_start;
                rd_ready  = !clr_start && !upd_valid;
                if (clr_start)
                    state_nxt = DRAIN;
                bram_we     = s2_valid;
                bram_w_addr = s2_valid ? s2_addr : '0;
                bram_din    = s2_valid ? s2_sum  : '0;
            end
            DRAIN: begin
                bram_we     = s2_valid;
                bram_w_addr = s2_valid ? s2_addr : '0;
                bram_din    = s2_valid ? s2_sum  : '0;
                if (!s1_valid && !s2_valid)
                    state_nxt = CLEAR;
            end
            default: state_nxt = CLEAR;
        endcase

        // Outputs sit at their idle values while reset is held
        if (rst) begin
            upd_ready   = 1'b0;
            rd_ready    = 1'b0;
            rd_valid    = 1'b0;
            rd_data     = '0;
            clr_done    = 1'b0;
            busy        = 1'b1;
            bram_we     = 1'b0;
            bram_w_addr = '0;
            bram_din    = '0;
        end
    end

    assign upd_acc = upd_valid && upd_ready;
    assign rd_acc  = rd_valid_in && rd_ready;

    // S0: accepted op presents its address to the read port this cycle
    always_comb begin
        if (upd_acc)
            bram_r_addr = upd_addr;
        else if (rd_acc)
            bram_r_addr = rd_addr;
        else
            bram_r_addr = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_rd    <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= (state == CLEAR) ? cnt + ADDR_W'(1) : '0;
            s1_valid <= upd_acc || rd_acc;
            s1_rd    <= rd_acc;
            s1_addr  <= upd_acc ? upd_addr : rd_addr;
            s1_inc   <= upd_data;
            // Reads occupy S1 only and never write
            s2_valid <= s1_valid && !s1_rd;
            s2_addr  <= s1_addr;
            s2_sum   <= s1_sum;
            s3_valid <= (state == DRAIN && state_nxt == CLEAR) ? 1'b0 : s2_valid;
            s3_addr  <= s2_addr;
            s3_sum   <= s2_sum;
        end
    end

endmodule

// File: doc/bram_rmw_ctrl.md
Name: bram_rmw_ctrl

Overview:
- Read-modify-write accumulation controller in front of one simple dual-port BRAM: 1 read port, 1 write port, 1-cycle registered read, no read/write collision check.
- Used in the gather phase. It accepts a stream of (vertex address, increment) updates and performs ram[addr] <= ram[addr] + inc at one update per cycle.
- Hazards between back-to-back same-address updates are resolved by forwarding.
- Also zero-initialises the BRAM after reset or on command, and serves host readback through the shared read port.

Parameters:
- DATA_W, 8, width of stored word and increment.
- ADDR_W, 10, BRAM address width; DEPTH = 2**ADDR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- upd_valid  in  1  update request valid.
- upd_ready  out  1  update accepted when valid&&ready.
- upd_addr  in  ADDR_W  update target address.
- upd_data  in  DATA_W  increment.
- rd_valid_in  in  1  host read request.
- rd_ready  out  1  host read accepted when rd_valid_in&&rd_ready.
- rd_addr  in  ADDR_W  host read address.
- rd_valid  out  1  read data valid, one-cycle pulse.
- rd_data  out  DATA_W  read result.
- clr_start  in  1  request full-memory zero clear.
- clr_done  out  1  one-cycle pulse at end of clear.
- busy  out  1  high whenever state != RUN.
- bram_r_addr  out  ADDR_W  to BRAM read address.
- bram_dout  in  DATA_W  from BRAM read data.
- bram_w_addr  out  ADDR_W  to BRAM write address.
- bram_we  out  1  to BRAM write enable.
- bram_din  out  DATA_W  to BRAM write data.

Behaviour:
- States: CLEAR, RUN, DRAIN.
  - rst → CLEAR, clear counter 0, all pipeline valids 0.
  - CLEAR: each cycle bram_we=1, bram_w_addr=counter, bram_din=0, counter++. After writing DEPTH-1 → RUN, clr_done=1 that cycle. A full clear takes DEPTH cycles.
  - RUN: clr_start → DRAIN. Nothing is accepted in the cycle clr_start is seen.
  - DRAIN: no accepts. When S1 and S2 are both empty → CLEAR, counter 0, S3 invalidated.
  - clr_start is ignored in CLEAR and DRAIN.
- Reset values: upd_ready=0, rd_ready=0, rd_valid=0, rd_data=0, clr_done=0, busy=1, bram_we=0, bram_w_addr=0, bram_din=0.
- Arbitration in RUN:
  - upd_ready=1.
  - rd_ready = !upd_valid; updates have strict priority, and host reads may starve (accepted).
  - Accepted op drives bram_r_addr = its address in the same cycle (stage S0).
- Pipeline (upd accepted at cycle t):
  - S1 at t+1: old = forwarded or bram_dout; sum = old + inc, modulo 2**DATA_W (wraps, no saturation).
  - S2 at t+2: bram_we=1, bram_w_addr=addr, bram_din=sum.
  - S3: copy of the last S2 write (addr, sum, valid), held one cycle.
- Forwarding in S1: if S2 is valid and its addr matches → use S2.sum; else if S3 is valid and its addr matches → use S3.sum; else bram_dout.
  - S3 covers the read that sampled the BRAM on the same edge as the write.
- Host read accepted at t:
  - rd_valid=1 at t+1, rd_data = forwarded-or-bram_dout value, same forwarding rule as S1.
  - Reads occupy S1 only and never write.
- Throughput: 1 update/cycle sustained. Update latency is 3 cycles from accept until the value is visible in the BRAM; it is visible to forwarding earlier.
- bram_we=0 in RUN/DRAIN when S2 is invalid. bram_r_addr don't-care when idle; drive 0.
- rst mid-operation: in-flight S1/S2 ops are dropped (not written), rd_valid is suppressed, and a full clear restarts.
- Simultaneous upd_valid and rd_valid_in: the update is taken, the read waits.

Test Plan (DATA_W=8, ADDR_W=4, DEPTH=16):
- Reset → bram_we=1 for exactly 16 cycles, addresses 0..15, data 0. clr_done pulses on the 16th. Then busy=0, upd_ready=1.
- Updates (3,+5), (7,+2) on separate cycles, then host reads of 3 and 7 → rd_data 5 and 2, each one cycle after accept.
- Back-to-back updates to address 5 of +1, +2, +3, +4 on consecutive cycles → writes 1, 3, 6, 10. Read of 5 → 10; exercises S2 and S3 forwarding.
- Pattern (9,+1), (2,+1), (9,+1) on consecutive cycles → address 9 final value 2; exercises the S3 path.
- Address 4 preloaded to 250 via updates, then +10 → stored 4; checks wrap.
- upd_valid held high with rd_valid_in=1 → rd_ready=0 throughout. Drop upd_valid → read accepted next cycle.
- clr_start while two updates are in flight → both writes complete, then a 16-cycle clear, then every address reads 0. rst asserted mid-clear → clear restarts from address 0.
